// File: rtl/prio_label_reader_if.sv
// Heap-side read port and egress valid/ready stream of the EDF dequeue controller.
// master = reader view, slave = heap/egress view.
interface prio_label_reader_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  heap_empty;
  logic                  heap_valid;
  logic [DATA_WIDTH-1:0] heap_dout;
  logic                  heap_re;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_late;

  modport master (
    input  heap_empty, heap_valid, heap_dout, out_ready,
    output heap_re, out_valid, out_data, out_late
  );

  modport slave (
    output heap_empty, heap_valid, heap_dout, out_ready,
    input  heap_re, out_valid, out_data, out_late
  );
endinterface

// File: rtl/prio_label_reader.sv
// Dequeue controller for the EDF label heap: one read in flight, expired-label drop/flag.
// Entry appears on out_valid the cycle after heap_valid rises; out_ready low stalls further heap reads.
module prio_label_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int LABEL_WIDTH = 8,
  parameter int DROP_LATE   = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  prio_label_reader_if.master    bus,
  output logic [LABEL_WIDTH-1:0] now,
  output logic [15:0]            drop_cnt,
  output logic                   err_timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;

  logic [1:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_hv_prev;
  logic                   r_heap_re;
  logic                   r_out_valid;
  logic [DATA_WIDTH-1:0]  r_out_data;
  logic                   r_out_late;
  logic [LABEL_WIDTH-1:0] r_now;
  logic [15:0]            r_drop_cnt;
  logic                   r_err;

  logic [LABEL_WIDTH-1:0] w_label;
  logic [LABEL_WIDTH-1:0] w_diff;
  logic                   w_late;
  logic                   w_rise;
  logic                   w_issue;
  logic                   w_accept;
  logic                   w_drop;

  // Wrap-safe expiry: a label in the half-window behind now gives a negative difference.
  assign w_label  = bus.heap_dout[DATA_WIDTH-1 -: LABEL_WIDTH];
  assign w_diff   = w_label - r_now;
  assign w_late   = w_diff[LABEL_WIDTH-1];
  assign w_rise   = bus.heap_valid & ~r_hv_prev;
  assign w_issue  = ~bus.heap_empty & ~bus.heap_valid & ~r_out_valid;
  assign w_accept = r_out_valid & bus.out_ready;
  assign w_drop   = w_late && (DROP_LATE != 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hv_prev   <= 1'b0;
      r_heap_re   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_late  <= 1'b0;
      r_now       <= '0;
      r_drop_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_hv_prev <= bus.heap_valid;
      r_heap_re <= 1'b0;
      if (tick) r_now <= r_now + LABEL_WIDTH'(1);
      if (w_accept) r_out_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_issue) begin
            r_heap_re <= 1'b1;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_rise) begin
            r_state <= S_SETTLE;
            if (w_drop) begin
              if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
            end else begin
              r_out_valid <= 1'b1;
              r_out_data  <= bus.heap_dout;
              r_out_late  <= w_late;
            end
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // Heap is still sifting while valid is high; a new read before it drops is unsafe.
        S_SETTLE: begin
          if (!bus.heap_valid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.heap_re   = r_heap_re;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_late  = r_out_late;
  assign now           = r_now;
  assign drop_cnt      = r_drop_cnt;
  assign err_timeout   = r_err;
endmodule

// File: tb/tb_prio_label_reader.sv
// Bench for prio_label_reader: two instances (drop / flag late) fed by behavioural min-heaps.
module tb_prio_label_reader;
  localparam int DW = 16;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst, tick, rdy, mute;
  always #5 clk = ~clk;

  prio_label_reader_if #(.DATA_WIDTH(DW)) if0 ();
  prio_label_reader_if #(.DATA_WIDTH(DW)) if1 ();
  logic [7:0]  now0, now1;
  logic [15:0] drop0, drop1;
  logic        err0, err1;

  prio_label_reader #(.DATA_WIDTH(DW), .LABEL_WIDTH(8), .DROP_LATE(1), .TIMEOUT(TO)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .bus(if0.master),
    .now(now0), .drop_cnt(drop0), .err_timeout(err0));
  prio_label_reader #(.DATA_WIDTH(DW), .LABEL_WIDTH(8), .DROP_LATE(0), .TIMEOUT(TO)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .bus(if1.master),
    .now(now1), .drop_cnt(drop1), .err_timeout(err1));

  logic [15:0] mem [2][16];
  int          hcnt [2];
  int          lat [2];
  int          sift [2];
  logic        hv [2];
  logic [15:0] hdout [2];
  int          re_cnt [2];
  int          re_long [2];
  int          re_bad [2];
  logic        re_prev [2];
  int          cyc = 0;
  logic [16:0] rx0[$], rx1[$], exp0[$], exp1[$];
  logic [15:0] batch[$];
  int          exp_drop;
  logic [7:0]  m_now;
  int          errors = 0;
  int          checks = 0;
  bit          drain_ok;

  assign if0.heap_empty = (hcnt[0] == 0);
  assign if1.heap_empty = (hcnt[1] == 0);
  assign if0.heap_valid = hv[0];
  assign if1.heap_valid = hv[1];
  assign if0.heap_dout  = hdout[0];
  assign if1.heap_dout  = hdout[1];
  assign if0.out_ready  = rdy;
  assign if1.out_ready  = rdy;

  task automatic heap_reset();
    for (int k = 0; k < 2; k++) begin
      hcnt[k] = 0; lat[k] = 0; sift[k] = 0; hv[k] = 1'b0; hdout[k] = 16'h0; re_prev[k] = 1'b0;
    end
  endtask

  // Behavioural heap: pop the smallest entry on a read, valid after a random latency, held for a random sift time.
  task automatic heap_step(input int k, input logic re);
    int idx;
    if (sift[k] > 0) begin
      sift[k]--;
      if (sift[k] == 0) hv[k] = 1'b0;
    end
    if (lat[k] > 0) begin
      lat[k]--;
      if (lat[k] == 0) begin
        hv[k] = 1'b1;
        sift[k] = int'($urandom_range(4, 1));
      end
    end
    if (re && !mute && hcnt[k] > 0) begin
      idx = 0;
      for (int i = 1; i < hcnt[k]; i++) if (mem[k][i] < mem[k][idx]) idx = i;
      hdout[k] = mem[k][idx];
      mem[k][idx] = mem[k][hcnt[k]-1];
      hcnt[k]--;
      lat[k] = int'($urandom_range(4, 1));
    end
  endtask

  task automatic mon(input int k, input logic re, input logic ov, input logic [16:0] od);
    if (re && re_prev[k]) re_long[k]++;
    if (re && (ov || hv[k])) re_bad[k]++;
    if (re) re_cnt[k]++;
    re_prev[k] = re;
    if (ov && rdy) begin
      if (k == 0) rx0.push_back(od);
      else        rx1.push_back(od);
    end
    heap_step(k, re);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) heap_reset();
    else begin
      mon(0, if0.heap_re, if0.out_valid, {if0.out_late, if0.out_data});
      mon(1, if1.heap_re, if1.out_valid, {if1.out_late, if1.out_data});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic in_past(input logic [7:0] label, input logic [7:0] t);
    logic [7:0] age;
    age = t - label;
    return (age >= 8'd1) && (age <= 8'd128);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_both(input logic [15:0] v);
    mem[0][hcnt[0]] = v; hcnt[0]++;
    mem[1][hcnt[1]] = v; hcnt[1]++;
  endtask

  task automatic advance_to(input logic [7:0] target);
    int n;
    n = int'(8'(target - m_now));
    if (n > 0) begin
      tick = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      tick = 1'b0;
    end
    m_now = target;
  endtask

  task automatic drain();
    drain_ok = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      if (hcnt[0] == 0 && hcnt[1] == 0 && lat[0] == 0 && lat[1] == 0 && !hv[0] && !hv[1]
          && !if0.out_valid && !if1.out_valid) begin
        drain_ok = 1;
        break;
      end
    end
    repeat (2) step();
  endtask

  // Expected stream: heap order is ascending label; the late rule decides drop (dut0) or flag (dut1).
  task automatic run_batch();
    logic [15:0] sorted[$];
    logic lt;
    rx0.delete(); rx1.delete(); exp0.delete(); exp1.delete();
    foreach (batch[i]) push_both(batch[i]);
    sorted = batch;
    sorted.sort();
    foreach (sorted[i]) begin
      lt = in_past(sorted[i][15:8], m_now);
      if (lt) exp_drop++;
      else exp0.push_back({1'b0, sorted[i]});
      exp1.push_back({lt, sorted[i]});
    end
    drain();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; rdy = 1'b0; mute = 1'b0;
    heap_reset();
    for (int k = 0; k < 2; k++) begin re_cnt[k] = 0; re_long[k] = 0; re_bad[k] = 0; end
    m_now = 8'h00; exp_drop = 0;
    repeat (3) @(negedge clk);
    #2;
    checks++; if ({if0.out_valid, if0.heap_re, if0.out_late, if1.out_valid, if1.heap_re, if1.out_late} !== 6'b0) begin
      errors++; $display("FAIL reset_ctl: got %b required 000000", {if0.out_valid, if0.heap_re, if0.out_late, if1.out_valid, if1.heap_re, if1.out_late}); end
    checks++; if (if0.out_data !== 16'h0 || if1.out_data !== 16'h0) begin
      errors++; $display("FAIL reset_data: got %h/%h required 0000", if0.out_data, if1.out_data); end
    checks++; if (now0 !== 8'h0 || now1 !== 8'h0) begin
      errors++; $display("FAIL reset_now: got %h/%h required 00", now0, now1); end
    checks++; if (drop0 !== 16'h0 || drop1 !== 16'h0 || err0 !== 1'b0 || err1 !== 1'b0) begin
      errors++; $display("FAIL reset_cnt: drop %h/%h err %b/%b required 0", drop0, drop1, err0, err1); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_order();
    rdy = 1'b1;
    batch = '{ {8'h30, 8'($urandom)}, {8'h10, 8'($urandom)}, {8'h20, 8'($urandom)} };
    run_batch();
    checks++; if (!drain_ok) begin errors++; $display("FAIL order_drain: idle=0 required 1"); end
    checks++; if (rx0.size() != exp0.size() || rx1.size() != exp1.size()) begin
      errors++; $display("FAIL order_count: got %0d/%0d required %0d/%0d", rx0.size(), rx1.size(), exp0.size(), exp1.size()); end
    else begin
      foreach (exp0[i]) begin checks++; if (rx0[i] !== exp0[i]) begin errors++; $display("FAIL order_d0[%0d]: got %h required %h", i, rx0[i], exp0[i]); end end
      foreach (exp1[i]) begin checks++; if (rx1[i] !== exp1[i]) begin errors++; $display("FAIL order_d1[%0d]: got %h required %h", i, rx1[i], exp1[i]); end end
    end
    checks++; if (drop0 !== 16'(exp_drop) || drop1 !== 16'h0) begin
      errors++; $display("FAIL order_drop: got %0d/%0d required %0d/0", drop0, drop1, exp_drop); end
    checks++; if (re_long[0] != 0 || re_long[1] != 0 || re_bad[0] != 0 || re_bad[1] != 0) begin
      errors++; $display("FAIL order_re: long %0d/%0d bad %0d/%0d required 0", re_long[0], re_long[1], re_bad[0], re_bad[1]); end
    checks++; if (re_cnt[0] != 3 || re_cnt[1] != 3) begin
      errors++; $display("FAIL order_re_cnt: got %0d/%0d required 3", re_cnt[0], re_cnt[1]); end
  endtask

  task automatic test_backpressure();
    logic [15:0] v, w;
    int rc0, rc1;
    bit seen;
    v = {8'h50, 8'($urandom)};
    w = {8'h60, 8'($urandom)};
    rdy = 1'b0;
    rx0.delete(); rx1.delete();
    push_both(v);
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (if0.out_valid && if1.out_valid) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_valid: out_valid=0 required 1 within 50 cycles"); end
    rc0 = re_cnt[0]; rc1 = re_cnt[1];
    push_both(w);
    repeat (20) begin
      step();
      checks++; if ({if0.out_valid, if0.out_late, if0.out_data} !== {2'b10, v} || {if1.out_valid, if1.out_late, if1.out_data} !== {2'b10, v}) begin
        errors++; $display("FAIL bp_hold: got %b%b %h / %b%b %h required 10 %h", if0.out_valid, if0.out_late, if0.out_data, if1.out_valid, if1.out_late, if1.out_data, v); end
    end
    checks++; if (re_cnt[0] != rc0 || re_cnt[1] != rc1) begin
      errors++; $display("FAIL bp_no_re: got %0d/%0d required %0d/%0d", re_cnt[0], re_cnt[1], rc0, rc1); end
    rdy = 1'b1;
    step();
    checks++; if (rx0.size() != 1 || rx1.size() != 1 || if0.out_valid !== 1'b0 || if1.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_accept: rx %0d/%0d valid %b/%b required 1/1 0/0", rx0.size(), rx1.size(), if0.out_valid, if1.out_valid); end
    else begin
      checks++; if (rx0[0] !== {1'b0, v} || rx1[0] !== {1'b0, v}) begin
        errors++; $display("FAIL bp_data: got %h/%h required %h", rx0[0], rx1[0], {1'b0, v}); end
    end
    drain();
    checks++; if (!drain_ok || rx0.size() != 2 || rx1.size() != 2) begin
      errors++; $display("FAIL bp_second: idle %0d rx %0d/%0d required 1 2/2", drain_ok, rx0.size(), rx1.size()); end
    else begin
      checks++; if (rx0[1] !== {1'b0, w} || rx1[1] !== {1'b0, w}) begin
        errors++; $display("FAIL bp_second_data: got %h/%h required %h", rx0[1], rx1[1], {1'b0, w}); end
    end
  endtask

  task automatic test_late();
    advance_to(8'h40);
    checks++; if (now0 !== 8'h40 || now1 !== 8'h40) begin
      errors++; $display("FAIL late_now: got %h/%h required 40", now0, now1); end
    batch = '{ {8'h3F, 8'($urandom)}, {8'h41, 8'($urandom)} };
    run_batch();
    checks++; if (!drain_ok) begin errors++; $display("FAIL late_drain: idle=0 required 1"); end
    checks++; if (rx0.size() != exp0.size() || rx1.size() != exp1.size()) begin
      errors++; $display("FAIL late_count: got %0d/%0d required %0d/%0d", rx0.size(), rx1.size(), exp0.size(), exp1.size()); end
    else begin
      foreach (exp0[i]) begin checks++; if (rx0[i] !== exp0[i]) begin errors++; $display("FAIL late_d0[%0d]: got %h required %h", i, rx0[i], exp0[i]); end end
      foreach (exp1[i]) begin checks++; if (rx1[i] !== exp1[i]) begin errors++; $display("FAIL late_d1[%0d]: got %h required %h", i, rx1[i], exp1[i]); end end
    end
    checks++; if (drop0 !== 16'(exp_drop) || drop1 !== 16'h0) begin
      errors++; $display("FAIL late_drop: got %0d/%0d required %0d/0", drop0, drop1, exp_drop); end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin
        advance_to(8'hF8);
        batch = '{ {8'h02, 8'($urandom)}, {8'hF8, 8'($urandom)} };
      end else begin
        advance_to(8'h02);
        batch = '{ {8'hF8, 8'($urandom)}, {8'h81, 8'($urandom)}, {8'h82, 8'($urandom)} };
      end
      run_batch();
      checks++; if (!drain_ok) begin errors++; $display("FAIL wrap_drain[%0d]: idle=0 required 1", r); end
      checks++; if (rx0.size() != exp0.size() || rx1.size() != exp1.size()) begin
        errors++; $display("FAIL wrap_count[%0d]: got %0d/%0d required %0d/%0d", r, rx0.size(), rx1.size(), exp0.size(), exp1.size()); end
      else begin
        foreach (exp0[i]) begin checks++; if (rx0[i] !== exp0[i]) begin errors++; $display("FAIL wrap_d0[%0d.%0d]: got %h required %h", r, i, rx0[i], exp0[i]); end end
        foreach (exp1[i]) begin checks++; if (rx1[i] !== exp1[i]) begin errors++; $display("FAIL wrap_d1[%0d.%0d]: got %h required %h", r, i, rx1[i], exp1[i]); end end
      end
      checks++; if (drop0 !== 16'(exp_drop)) begin
        errors++; $display("FAIL wrap_drop[%0d]: got %0d required %0d", r, drop0, exp_drop); end
    end
  endtask

  task automatic test_random();
    logic [7:0] lab [3];
    for (int r = 0; r < 6; r++) begin
      advance_to(8'($urandom));
      lab[0] = 8'($urandom);
      do lab[1] = 8'($urandom); while (lab[1] == lab[0]);
      do lab[2] = 8'($urandom); while (lab[2] == lab[0] || lab[2] == lab[1]);
      batch = '{ {lab[0], 8'($urandom)}, {lab[1], 8'($urandom)}, {lab[2], 8'($urandom)} };
      run_batch();
      checks++; if (!drain_ok || rx0.size() != exp0.size() || rx1.size() != exp1.size()) begin
        errors++; $display("FAIL rand_count[%0d]: idle %0d got %0d/%0d required %0d/%0d", r, drain_ok, rx0.size(), rx1.size(), exp0.size(), exp1.size()); end
      else begin
        foreach (exp0[i]) begin checks++; if (rx0[i] !== exp0[i]) begin errors++; $display("FAIL rand_d0[%0d.%0d]: got %h required %h", r, i, rx0[i], exp0[i]); end end
        foreach (exp1[i]) begin checks++; if (rx1[i] !== exp1[i]) begin errors++; $display("FAIL rand_d1[%0d.%0d]: got %h required %h", r, i, rx1[i], exp1[i]); end end
      end
      checks++; if (drop0 !== 16'(exp_drop) || drop1 !== 16'h0) begin
        errors++; $display("FAIL rand_drop[%0d]: got %0d/%0d required %0d/0", r, drop0, drop1, exp_drop); end
    end
    checks++; if (re_long[0] != 0 || re_long[1] != 0 || re_bad[0] != 0 || re_bad[1] != 0 || err0 !== 1'b0 || err1 !== 1'b0) begin
      errors++; $display("FAIL rand_re: long %0d/%0d bad %0d/%0d err %b/%b required 0", re_long[0], re_long[1], re_bad[0], re_bad[1], err0, err1); end
  endtask

  task automatic test_timeout();
    int t0, t1;
    bit seen;
    mute = 1'b1;
    push_both({8'h70, 8'($urandom)});
    seen = 0; t0 = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (if0.heap_re) begin seen = 1; t0 = cyc; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL to_re: heap_re=0 required 1 within 10 cycles"); end
    t1 = -1;
    for (int c = 0; c < TO + 10; c++) begin
      step();
      if (err0) begin t1 = cyc; break; end
    end
    checks++; if (t1 - t0 != TO) begin
      errors++; $display("FAIL to_delay: got %0d cycles required %0d", t1 - t0, TO); end
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL to_err1: got %b required 1", err1); end
    repeat (2 * TO) step();
    checks++; if (err0 !== 1'b1 || err1 !== 1'b1) begin
      errors++; $display("FAIL to_sticky: got %b/%b required 1/1", err0, err1); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++; if (err0 !== 1'b0 || err1 !== 1'b0) begin
      errors++; $display("FAIL to_async_clear: got %b/%b required 0/0", err0, err1); end
    checks++; if (drop0 !== 16'h0 || now0 !== 8'h0 || if0.out_valid !== 1'b0 || if0.heap_re !== 1'b0) begin
      errors++; $display("FAIL to_async_state: drop %0d now %h valid %b re %b required 0", drop0, now0, if0.out_valid, if0.heap_re); end
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0; mute = 1'b0; m_now = 8'h00; exp_drop = 0;
    batch = '{ {8'h05, 8'($urandom)} };
    run_batch();
    checks++; if (!drain_ok || rx0.size() != 1 || rx1.size() != 1) begin
      errors++; $display("FAIL to_recover: idle %0d rx %0d/%0d required 1 1/1", drain_ok, rx0.size(), rx1.size()); end
    else begin
      checks++; if (rx0[0] !== exp0[0] || rx1[0] !== exp1[0]) begin
        errors++; $display("FAIL to_recover_data: got %h/%h required %h/%h", rx0[0], rx1[0], exp0[0], exp1[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_backpressure();
    test_late();
    test_wrap();
    test_random();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
